// File: rtl/alu_operand_issue_if.sv
// Handshake bundle between the decode stage, the writeback forwarding bus and the ALU.
// The slave modport is the issue buffer's view; master is the driving side.
interface alu_operand_issue_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [REG_AW-1:0] in_rs_idx;
    logic [REG_AW-1:0] in_rt_idx;
    logic [DATA_W-1:0] in_rs_data;
    logic [DATA_W-1:0] in_rt_data;
    logic [REG_AW-1:0] in_rd_idx;
    logic [15:0]       in_imm;
    logic [4:0]        in_shamt;
    logic [1:0]        in_b_sel;

    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [DATA_W-1:0] fwd_data;

    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_control_signal;
    logic [DATA_W-1:0] out_world_a;
    logic [DATA_W-1:0] out_world_b;
    logic [REG_AW-1:0] out_rd;

    modport slave (
        input  in_valid, in_op, in_rs_idx, in_rt_idx, in_rs_data, in_rt_data,
               in_rd_idx, in_imm, in_shamt, in_b_sel,
               fwd_valid, fwd_rd, fwd_data, out_ready,
        output in_ready, out_valid, out_control_signal, out_world_a, out_world_b, out_rd
    );

    modport master (
        output in_valid, in_op, in_rs_idx, in_rt_idx, in_rs_data, in_rt_data,
               in_rd_idx, in_imm, in_shamt, in_b_sel,
               fwd_valid, fwd_rd, fwd_data, out_ready,
        input  in_ready, out_valid, out_control_signal, out_world_a, out_world_b, out_rd
    );
endinterface

// File: rtl/alu_operand_issue.sv
// ALU issue buffer: builds operands at capture, keeps register operands fresh by
// snooping the writeback bus, and presents ops in order through a small FIFO.
module alu_operand_issue #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst,
    alu_operand_issue_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [3:0]        op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] a_idx;
        logic [REG_AW-1:0] b_idx;
        logic              a_is_reg;
        logic              b_is_reg;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } entry_t;

    logic [CNT_W-1:0] count_reg, count_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;

    entry_t [DEPTH-1:0] ent_all;
    entry_t             new_entry;
    entry_t             head;

    logic push;
    logic pop;
    logic out_valid_int;

    assign bus.in_ready  = rst || (count_reg < CNT_W'(DEPTH));
    assign out_valid_int = !rst && (count_reg != '0);
    assign push          = !rst && bus.in_valid && (count_reg < CNT_W'(DEPTH));
    assign pop           = out_valid_int && bus.out_ready;

    // Operand capture: shift ops take A from rt; index 0 is hard zero.
    logic [REG_AW-1:0] a_src_idx;
    logic [DATA_W-1:0] a_src_data;
    logic [DATA_W-1:0] a_val;
    logic [DATA_W-1:0] rt_val;

    always_comb begin
        a_src_idx  = (bus.in_b_sel == 2'b11) ? bus.in_rt_idx  : bus.in_rs_idx;
        a_src_data = (bus.in_b_sel == 2'b11) ? bus.in_rt_data : bus.in_rs_data;

        if (a_src_idx == '0)
            a_val = '0;
        else if (bus.fwd_valid && (bus.fwd_rd == a_src_idx))
            a_val = bus.fwd_data;
        else
            a_val = a_src_data;

        if (bus.in_rt_idx == '0)
            rt_val = '0;
        else if (bus.fwd_valid && (bus.fwd_rd == bus.in_rt_idx))
            rt_val = bus.fwd_data;
        else
            rt_val = bus.in_rt_data;

        new_entry          = '0;
        new_entry.op       = bus.in_op;
        new_entry.rd       = bus.in_rd_idx;
        new_entry.a_idx    = a_src_idx;
        new_entry.b_idx    = bus.in_rt_idx;
        new_entry.a_is_reg = (a_src_idx != '0);
        new_entry.b_is_reg = (bus.in_b_sel == 2'b00) && (bus.in_rt_idx != '0);
        new_entry.a        = a_val;
        unique case (bus.in_b_sel)
            2'b00:   new_entry.b = rt_val;
            2'b01:   new_entry.b = {{(DATA_W-16){bus.in_imm[15]}}, bus.in_imm};
            2'b10:   new_entry.b = {{(DATA_W-16){1'b0}}, bus.in_imm};
            default: new_entry.b = {{(DATA_W-5){1'b0}}, bus.in_shamt};
        endcase
    end

    // Each slot either loads a fresh op or snoops writeback for its register operands.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            entry_t ent_reg;
            logic   load;
            logic   hit_a;
            logic   hit_b;

            assign load  = push && (wr_ptr_reg == PTR_W'(gi));
            assign hit_a = bus.fwd_valid && ent_reg.a_is_reg && (ent_reg.a_idx == bus.fwd_rd);
            assign hit_b = bus.fwd_valid && ent_reg.b_is_reg && (ent_reg.b_idx == bus.fwd_rd);

            always_ff @(posedge clk) begin
                if (rst) begin
                    ent_reg <= '0;
                end else if (load) begin
                    ent_reg <= new_entry;
                end else begin
                    if (hit_a)
                        ent_reg.a <= bus.fwd_data;
                    if (hit_b)
                        ent_reg.b <= bus.fwd_data;
                end
            end

            assign ent_all[gi] = ent_reg;
        end
    endgenerate

    always_comb begin
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (push)
            wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
        if (pop)
            rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
        if (push && !pop)
            count_next = count_reg + 1'b1;
        else if (pop && !push)
            count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
        end
    end

    // Data outputs are forced to zero whenever no valid head is presented.
    assign head                   = ent_all[rd_ptr_reg];
    assign bus.out_valid          = out_valid_int;
    assign bus.out_control_signal = out_valid_int ? head.op : 4'h0;
    assign bus.out_world_a        = out_valid_int ? head.a  : '0;
    assign bus.out_world_b        = out_valid_int ? head.b  : '0;
    assign bus.out_rd             = out_valid_int ? head.rd : '0;
endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed bench for alu_operand_issue: hand-computed operands, ordering, stall,
// forwarding/snoop and reset behaviour.
module tb_alu_operand_issue;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SLL = 4'h3;
    localparam logic [3:0] OP_BAD = 4'hF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    alu_operand_issue_if #(.DATA_W(32), .REG_AW(5)) bus();

    alu_operand_issue #(.DATA_W(32), .REG_AW(5), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [4:0] rs, input logic [31:0] rsd,
                          input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd,
                          input logic [15:0] imm, input logic [4:0] sh, input logic [1:0] bsel);
        bus.in_valid   = 1'b1;
        bus.in_op      = op;
        bus.in_rs_idx  = rs;
        bus.in_rs_data = rsd;
        bus.in_rt_idx  = rt;
        bus.in_rt_data = rtd;
        bus.in_rd_idx  = rd;
        bus.in_imm     = imm;
        bus.in_shamt   = sh;
        bus.in_b_sel   = bsel;
    endtask

    task automatic set_fwd(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.fwd_valid = v;
        bus.fwd_rd    = rd;
        bus.fwd_data  = d;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_op(4'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 16'h0, 5'd0, 2'b00);
        bus.in_valid = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0);

        tick();
        tick();
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        rst = 1'b0;

        // Basic ADD with register operands, one-cycle latency.
        bus.out_ready = 1'b1;
        set_op(OP_ADD, 5'd3, 32'd5, 5'd4, 32'd7, 5'd9, 16'h0, 5'd0, 2'b00);
        #1;
        check("add_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("add_valid", {31'b0, bus.out_valid}, 32'd1);
        check("add_a", bus.out_world_a, 32'd5);
        check("add_b", bus.out_world_b, 32'd7);
        check("add_ctrl", {28'b0, bus.out_control_signal}, {28'b0, OP_ADD});
        check("add_rd", {27'b0, bus.out_rd}, 32'd9);
        tick();
        check("add_drained", {31'b0, bus.out_valid}, 32'd0);

        // Sign and zero extended immediates, back to back.
        set_op(OP_ADD, 5'd1, 32'h10, 5'd2, 32'h99, 5'd4, 16'hFFFC, 5'd0, 2'b01);
        tick();
        set_op(OP_ADD, 5'd1, 32'h10, 5'd2, 32'h99, 5'd5, 16'hFFFC, 5'd0, 2'b10);
        check("sext_a", bus.out_world_a, 32'h10);
        check("sext_b", bus.out_world_b, 32'hFFFF_FFFC);
        tick();
        bus.in_valid = 1'b0;
        check("zext_b", bus.out_world_b, 32'h0000_FFFC);
        check("zext_rd", {27'b0, bus.out_rd}, 32'd5);
        tick();
        check("imm_drained", {31'b0, bus.out_valid}, 32'd0);

        // Stall: fill, hold a third op, then drain in order.
        bus.out_ready = 1'b0;
        set_op(4'h1, 5'd1, 32'h11, 5'd2, 32'h22, 5'd1, 16'h0, 5'd0, 2'b00);
        tick();
        set_op(4'h1, 5'd1, 32'h33, 5'd2, 32'h44, 5'd2, 16'h0, 5'd0, 2'b00);
        tick();
        set_op(4'h1, 5'd1, 32'h55, 5'd2, 32'h66, 5'd3, 16'h0, 5'd0, 2'b00);
        check("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("stall_head_a", bus.out_world_a, 32'h11);
        tick();
        check("stall_still_full", {31'b0, bus.in_ready}, 32'd0);
        check("stall_stable_a", bus.out_world_a, 32'h11);
        check("stall_stable_rd", {27'b0, bus.out_rd}, 32'd1);
        bus.out_ready = 1'b1;
        tick();
        check("drain_b_rd", {27'b0, bus.out_rd}, 32'd2);
        check("drain_b_a", bus.out_world_a, 32'h33);
        check("pushpop_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("drain_c_rd", {27'b0, bus.out_rd}, 32'd3);
        check("drain_c_b", bus.out_world_b, 32'h66);
        check("pushpop_count_kept", {31'b0, bus.in_ready}, 32'd1);
        tick();
        check("drain_done", {31'b0, bus.out_valid}, 32'd0);

        // Forwarding at capture, then snooping on a stalled head.
        bus.out_ready = 1'b0;
        set_op(OP_ADD, 5'd3, 32'h1111, 5'd4, 32'h2, 5'd6, 16'h0, 5'd0, 2'b00);
        set_fwd(1'b1, 5'd3, 32'hDEAD);
        tick();
        bus.in_valid = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0);
        check("fwd_cap_a", bus.out_world_a, 32'hDEAD);
        check("fwd_cap_b", bus.out_world_b, 32'h2);
        set_fwd(1'b1, 5'd4, 32'hBEEF);
        tick();
        set_fwd(1'b0, 5'd0, 32'h0);
        check("snoop_b", bus.out_world_b, 32'hBEEF);
        check("snoop_a_kept", bus.out_world_a, 32'hDEAD);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        set_op(OP_ADD, 5'd3, 32'h1111, 5'd5, 32'h7, 5'd6, 16'h0010, 5'd0, 2'b01);
        tick();
        bus.in_valid = 1'b0;
        check("stall_pre_a", bus.out_world_a, 32'h1111);
        set_fwd(1'b1, 5'd3, 32'hDEAD);
        tick();
        check("snoop_head_a", bus.out_world_a, 32'hDEAD);
        set_fwd(1'b1, 5'd5, 32'hABCD);
        tick();
        set_fwd(1'b0, 5'd0, 32'h0);
        check("imm_not_snooped", bus.out_world_b, 32'h10);
        bus.out_ready = 1'b1;
        tick();
        set_op(OP_ADD, 5'd0, 32'h99, 5'd0, 32'h98, 5'd7, 16'h0, 5'd0, 2'b00);
        set_fwd(1'b1, 5'd0, 32'h77);
        tick();
        bus.in_valid = 1'b0;
        check("zero_idx_a", bus.out_world_a, 32'h0);
        check("zero_idx_b", bus.out_world_b, 32'h0);
        set_fwd(1'b1, 5'd0, 32'h55);
        bus.out_ready = 1'b0;
        tick();
        set_fwd(1'b0, 5'd0, 32'h0);
        check("zero_idx_no_snoop", bus.out_world_a, 32'h0);
        bus.out_ready = 1'b1;
        tick();

        // Shift: A from rt, B = shamt; unknown op code passes through.
        set_op(OP_SLL, 5'd9, 32'h123, 5'd1, 32'd1, 5'd8, 16'hFFFF, 5'd4, 2'b11);
        tick();
        set_op(OP_BAD, 5'd2, 32'h42, 5'd0, 32'h0, 5'd1, 16'h0, 5'd0, 2'b00);
        check("sll_a", bus.out_world_a, 32'd1);
        check("sll_b", bus.out_world_b, 32'd4);
        check("sll_ctrl", {28'b0, bus.out_control_signal}, {28'b0, OP_SLL});
        tick();
        bus.in_valid = 1'b0;
        check("bad_op_ctrl", {28'b0, bus.out_control_signal}, {28'b0, OP_BAD});
        check("bad_op_a", bus.out_world_a, 32'h42);
        tick();

        // Reset mid-stream with two ops queued and a third offered.
        bus.out_ready = 1'b0;
        set_op(OP_ADD, 5'd1, 32'hA1, 5'd2, 32'hB1, 5'd1, 16'h0, 5'd0, 2'b00);
        tick();
        set_op(OP_ADD, 5'd1, 32'hA2, 5'd2, 32'hB2, 5'd2, 16'h0, 5'd0, 2'b00);
        tick();
        check("pre_rst_full", {31'b0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mid_rst_a", bus.out_world_a, 32'h0);
        tick();
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        tick();
        check("post_rst_empty", {31'b0, bus.out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
